aes_subbytes_seq: RTL and testbench

//  Byte-serial AES SubBytes engine. Accepts a 128-bit AES state, streams its
//  16 bytes one per cycle through the single shared external sbox instance,

---
 rtl/aes_subbytes_seq_if.sv | 23 ++
 rtl/aes_subbytes_seq.sv | 119 +++++++++++
 tb/tb_aes_subbytes_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_subbytes_seq_if.sv
// Block handshake and external sbox bus of aes_subbytes_seq.
// slave = engine side, master = upstream controller / sbox side.
interface aes_subbytes_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;
  logic [7:0]   sbox_in;
  logic [7:0]   sbox_out;

  modport slave (
    input  in_valid, state_in, out_ready, sbox_out,
    output in_ready, out_valid, state_out, busy, sbox_in
  );

  modport master (
    output in_valid, state_in, out_ready, sbox_out,
    input  in_ready, out_valid, state_out, busy, sbox_in
  );
endinterface

// File: rtl/aes_subbytes_seq.sv
// Byte-serial AES SubBytes through one shared external sbox, 16 (or 17) cycles per block.
// Define AES_SUBBYTES_SHIFTROWS_EN to fuse ShiftRows into the result byte placement.
module aes_subbytes_seq #(
  parameter int SBOX_REG = 0
) (
  input logic               clk,
  input logic               rst_n,
  aes_subbytes_seq_if.slave bus
);

  // A registered sbox needs one extra cycle: issue runs one index ahead of capture.
  localparam int            CW       = (SBOX_REG != 0) ? 5 : 4;
  localparam logic [CW-1:0] LAST_CNT = CW'((SBOX_REG != 0) ? 16 : 15);
  localparam logic [CW-1:0] CAP_LAG  = CW'((SBOX_REG != 0) ? 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [127:0]  buf_q;
  logic [7:0]    buf_byte [16];
  logic [7:0]    res_q    [16];

  logic          accept;
  logic          run;
  logic          issue_en;
  logic          cap_en;
  logic [3:0]    issue_idx;
  logic [3:0]    cap_idx;
  logic [3:0]    wr_idx;

  function automatic logic [3:0] wr_map(input logic [3:0] idx);
`ifdef AES_SUBBYTES_SHIFTROWS_EN
    // idx = {col,row}; byte (r,c) lands in column (c-r) mod 4 of the same row
    return {idx[3:2] - idx[1:0], idx[1:0]};
`else
    return idx;
`endif
  endfunction

  assign run       = (state_q == S_RUN);
  assign accept    = (state_q == S_IDLE) && bus.in_valid;
  assign issue_idx = cnt_q[3:0];
  assign issue_en  = run && ((SBOX_REG == 0) || (cnt_q != LAST_CNT));
  assign cap_en    = run && ((SBOX_REG == 0) || (cnt_q != '0));
  assign cap_idx   = 4'(cnt_q - CAP_LAG);
  assign wr_idx    = wr_map(cap_idx);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        buf_q <= bus.state_in;
      end
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.sbox_in   = issue_en ? buf_byte[issue_idx] : 8'h00;

  // One result register per byte; state_out is their concatenation in FIPS-197 order.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
      assign buf_byte[gi] = buf_q[127-8*gi -: 8];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_q[gi] <= 8'h00;
        end else if (cap_en && (wr_idx == 4'(gi))) begin
          res_q[gi] <= bus.sbox_out;
        end
      end

      assign bus.state_out[127-8*gi -: 8] = res_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Randomised bench for aes_subbytes_seq: combinational-sbox and registered-sbox instances,
// checked against a GF(2^8) SubBytes/ShiftRows reference computed in the bench.
module tb_aes_subbytes_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         sel = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] state_in = '0;

  aes_subbytes_seq_if if0 ();
  aes_subbytes_seq_if if1 ();

  aes_subbytes_seq #(.SBOX_REG(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  aes_subbytes_seq #(.SBOX_REG(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_subbytes(input logic [127:0] s);
    logic [7:0]   m [4][4];
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = sbox_f(s[127-8*(4*c+r) -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
`ifdef AES_SUBBYTES_SHIFTROWS_EN
        o[127-8*(4*c+r) -: 8] = m[r][(c+r)%4];
`else
        o[127-8*(4*c+r) -: 8] = m[r][c];
`endif
    return o;
  endfunction

  // ---------------- environment: sbox models and steering ----------------
  logic [7:0] sb1_q = 8'h00;
  assign if0.sbox_out = sbox_f(if0.sbox_in);
  always @(posedge clk) sb1_q <= sbox_f(if1.sbox_in);
  assign if1.sbox_out = sb1_q;

  assign if0.in_valid  = in_valid & ~sel;
  assign if1.in_valid  = in_valid & sel;
  assign if0.state_in  = state_in;
  assign if1.state_in  = state_in;
  assign if0.out_ready = out_ready & ~sel;
  assign if1.out_ready = out_ready & sel;

  wire         o_in_ready  = sel ? if1.in_ready  : if0.in_ready;
  wire         o_out_valid = sel ? if1.out_valid : if0.out_valid;
  wire         o_busy      = sel ? if1.busy      : if0.busy;
  wire [7:0]   o_sbox_in   = sel ? if1.sbox_in   : if0.sbox_in;
  wire [127:0] o_state_out = sel ? if1.state_out : if0.state_out;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Accept one block, wait for the result, optionally stall, then hand it off.
  task automatic run_block(input logic [127:0] data, input int delay, input bit early_ready,
                           input bit poke, output int acc_cyc, output logic [127:0] got);
    int n;
    logic [127:0] exp;
    exp = ref_subbytes(data);
    check("in_ready_idle", 128'(o_in_ready), 128'(1));
    out_ready = early_ready;
    in_valid = 1'b1;
    state_in = data;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    check("run_flags", 128'({o_busy, o_in_ready, o_out_valid}), 128'(3'b100));
    check("sbox_in_first", 128'(o_sbox_in), 128'(data[127:120]));
    n = 0;
    while (!o_out_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (sel && n == 16) check("sbox_in_extra", 128'(o_sbox_in), 128'(0));
    end
    check("latency", 128'(n), sel ? 128'(17) : 128'(16));
    check("result", o_state_out, exp);
    got = o_state_out;
    if (!early_ready) begin
      for (int k = 0; k < delay; k++) begin
        in_valid = poke;
        state_in = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        check("hold_data", o_state_out, exp);
        check("hold_flags", 128'({o_out_valid, o_in_ready, o_busy}), 128'(3'b101));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("handoff_flags", 128'({o_out_valid, o_in_ready, o_busy}), 128'(3'b010));
    $display("txn sbox_reg=%0d in=%h out=%h lat=%0d stall=%0d", sel, data, got, n, delay);
  endtask

  localparam logic [127:0] V2_IN = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
`ifdef AES_SUBBYTES_SHIFTROWS_EN
  localparam logic [127:0] V2_EXP = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
`else
  localparam logic [127:0] V2_EXP = 128'hd42711aee0bf98f1b8b45de51e415230;
`endif

  initial begin
    int acc;
    int prev;
    logic [127:0] got;

    repeat (3) @(posedge clk);
    #1;
    check("rst0_flags", 128'({if0.in_ready, if0.out_valid, if0.busy}), 128'(3'b100));
    check("rst0_state_out", if0.state_out, 128'(0));
    check("rst0_sbox_in", 128'(if0.sbox_in), 128'(0));
    check("rst1_flags", 128'({if1.in_ready, if1.out_valid, if1.busy}), 128'(3'b100));
    check("rst1_state_out", if1.state_out, 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Combinational sbox instance
    sel = 1'b0;
    run_block(128'h0, 0, 1'b0, 1'b0, acc, got);
    check("zero_vector", got, {4{32'h63636363}});
    run_block(V2_IN, 0, 1'b0, 1'b0, acc, got);
    check("fips_vector", got, V2_EXP);
    run_block(V2_IN, 10, 1'b0, 1'b1, acc, got);
    check("stall_vector", got, V2_EXP);
    run_block(V2_IN, 0, 1'b1, 1'b0, acc, got);

    prev = 0;
    for (int b = 0; b < 4; b++) begin
      run_block({$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 1'b0, acc, got);
      if (b > 0) check("throughput", 128'(acc - prev), 128'(18));
      prev = acc;
    end
    for (int b = 0; b < 12; b++) begin
      run_block({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc, got);
    end

    // Reset in the middle of a block
    in_valid = 1'b1;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_flags", 128'({o_out_valid, o_in_ready, o_busy}), 128'(3'b010));
    check("midrst_state_out", o_state_out, 128'(0));
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_block(V2_IN, 1, 1'b0, 1'b0, acc, got);
    check("after_rst_vector", got, V2_EXP);

    // Registered sbox instance
    sel = 1'b1;
    run_block(V2_IN, 0, 1'b0, 1'b0, acc, got);
    check("reg_fips_vector", got, V2_EXP);
    prev = acc;
    run_block(128'h0, 0, 1'b0, 1'b0, acc, got);
    check("reg_throughput", 128'(acc - prev), 128'(19));
    for (int b = 0; b < 6; b++) begin
      run_block({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 3)),
                1'b0, 1'($urandom_range(0, 1)), acc, got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
